// File: rtl/cam_frame_writer.sv
// Drains fixed-length bursts of RGB565 words from the camera FIFO and writes them to
// SDRAM as linear frames, ping-ponging between two frame buffers.
module cam_frame_writer #(
    parameter int                BURST_LEN   = 8,
    parameter int                FRAME_WORDS = 307200,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE0       = 24'h000000,
    parameter logic [ADDR_W-1:0] BASE1       = 24'h080000,
    parameter int                CNT_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cam_data_count,
    input  logic [15:0]       cam_dout,
    output logic              cam_rd_en,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    input  logic              wr_next,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              disp_frame_sel,
    output logic              busy
);

    localparam int                IDX_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BURST_LEN - 1);
    localparam logic [CNT_W:0]    CNT_BURST  = (CNT_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_STREAM,
        S_ADV
    } state_t;

    state_t            state;
    logic              write_sel;
    logic [ADDR_W-1:0] word_ptr;
    logic [IDX_W-1:0]  rd_cnt;
    logic [IDX_W-1:0]  cap_cnt;
    logic [IDX_W-1:0]  idx;
    logic              cap_pend;
    logic [15:0]       line_buf [BURST_LEN];

    logic              count_ok;
    logic              last_of_frame;

    assign count_ok      = {1'b0, cam_data_count} >= CNT_BURST;
    assign last_of_frame = (word_ptr + BURST_STEP) == FRAME_END;

    // FIFO data arrives one cycle after its strobe, so capture follows the delayed strobe.
    always_ff @(posedge clk) begin
        if (state == S_FILL && cap_pend) begin
            line_buf[cap_cnt] <= cam_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            write_sel      <= 1'b0;
            word_ptr       <= '0;
            rd_cnt         <= '0;
            cap_cnt        <= '0;
            idx            <= '0;
            cap_pend       <= 1'b0;
            cam_rd_en      <= 1'b0;
            wr_req         <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            frame_done     <= 1'b0;
            disp_frame_sel <= 1'b1;
            busy           <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && count_ok) begin
                        state     <= S_FILL;
                        cam_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        rd_cnt    <= '0;
                        cap_cnt   <= '0;
                        cap_pend  <= 1'b0;
                    end
                end

                S_FILL: begin
                    cap_pend <= cam_rd_en;
                    if (cam_rd_en) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_IDX) begin
                            cam_rd_en <= 1'b0;
                        end
                    end
                    if (cap_pend) begin
                        cap_cnt <= cap_cnt + 1'b1;
                        if (cap_cnt == LAST_IDX) begin
                            state   <= S_REQ;
                            wr_req  <= 1'b1;
                            wr_addr <= (write_sel ? BASE1 : BASE0) + word_ptr;
                        end
                    end
                end

                // wr_addr is only loaded on REQ entry, so it stays stable until the ack.
                S_REQ: begin
                    if (wr_ack) begin
                        state   <= S_STREAM;
                        wr_req  <= 1'b0;
                        idx     <= '0;
                        wr_data <= line_buf[0];
                    end
                end

                S_STREAM: begin
                    if (wr_next) begin
                        if (idx == LAST_IDX) begin
                            state      <= S_ADV;
                            idx        <= '0;
                            frame_done <= last_of_frame;
                        end else begin
                            idx     <= idx + 1'b1;
                            wr_data <= line_buf[idx + 1'b1];
                        end
                    end
                end

                S_ADV: begin
                    if (last_of_frame) begin
                        word_ptr       <= '0;
                        disp_frame_sel <= write_sel;
                        write_sel      <= ~write_sel;
                    end else begin
                        word_ptr <= word_ptr + BURST_STEP;
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    cam_rd_en <= 1'b0;
                    wr_req    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: FIFO model, SDRAM write-port model acting as
// scoreboard monitor, and a main sequence covering bursts, frame wrap, enable and reset.
module tb_cam_frame_writer;

    localparam int BURST_LEN   = 8;
    localparam int FRAME_WORDS = 32;
    localparam int ADDR_W      = 24;
    localparam int CNT_W       = 10;

    // Clock / reset / DUT signals
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  cam_data_count = '0;
    logic [15:0]       cam_dout = '0;
    logic              cam_rd_en;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ack = 1'b0;
    logic              wr_next = 1'b0;
    logic [15:0]       wr_data;
    logic              frame_done;
    logic              disp_frame_sel;
    logic              busy;

    always #5 clk = ~clk;

    cam_frame_writer #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS),
        .ADDR_W     (ADDR_W),
        .BASE0      (24'h000000),
        .BASE1      (24'h080000),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cam_data_count(cam_data_count),
        .cam_dout      (cam_dout),
        .cam_rd_en     (cam_rd_en),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_ack        (wr_ack),
        .wr_next       (wr_next),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .disp_frame_sel(disp_frame_sel),
        .busy          (busy)
    );

    // Scoreboard state
    logic [15:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int checks = 0;
    int errors = 0;

    int fifo_wr = 0;
    int fifo_rd = 0;
    int underflow = 0;
    int rd_total = 0;
    int rd_run = 0;
    int frame_cnt = 0;
    int fd_run = 0;
    int burst_cnt = 0;
    int park_cnt = 0;
    int ack_delay = 1;
    int next_gap = 1;
    int stop_at = BURST_LEN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words are numbered 1,2,3,... in push order.
    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(16'(fifo_wr + 1));
            fifo_wr++;
        end
    endtask

    task automatic wait_bursts(input int n);
        int t;
        t = 0;
        while (burst_cnt < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("burst_timeout", 32'(burst_cnt >= n), 32'(1));
    endtask

    // Camera FIFO model: show-ahead-free, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (cam_rd_en) begin
            if (fifo_rd >= fifo_wr) begin
                underflow++;
            end else begin
                cam_dout <= 16'(fifo_rd + 1);
                fifo_rd++;
            end
        end
        cam_data_count <= CNT_W'(fifo_wr - fifo_rd);
    end

    // Read-strobe and frame_done pulse monitor.
    always @(negedge clk) begin
        if (cam_rd_en) begin
            rd_run++;
            rd_total++;
        end else if (rd_run != 0) begin
            check("rd_run_len", 32'(rd_run), 32'(BURST_LEN));
            rd_run = 0;
        end
        if (frame_done) begin
            fd_run++;
            if (fd_run == 1) frame_cnt++;
        end else if (fd_run != 0) begin
            check("frame_done_width", 32'(fd_run), 32'(1));
            fd_run = 0;
        end
    end

    // SDRAM write-port model: pops expected address/data and compares.
    initial begin : sdram_model
        logic [ADDR_W-1:0] a0;
        logic stable;
        logic parked;
        forever begin
            @(negedge clk);
            if (wr_req) begin
                if (exp_addr_q.size() == 0) check("addr_underrun", 32'(1), 32'(0));
                else check("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
                a0 = wr_addr;
                stable = 1'b1;
                repeat (ack_delay) begin
                    @(negedge clk);
                    if (!wr_req || wr_addr != a0) stable = 1'b0;
                end
                check("req_stable", 32'(stable), 32'(1));
                wr_ack = 1'b1;
                @(negedge clk);
                wr_ack = 1'b0;
                check("req_dropped", 32'(wr_req), 32'(0));
                parked = 1'b0;
                for (int k = 0; k < BURST_LEN; k++) begin
                    if (k == stop_at) begin
                        parked = 1'b1;
                        break;
                    end
                    wr_next = 1'b1;
                    if (exp_q.size() == 0) check("data_underrun", 32'(1), 32'(0));
                    else check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
                    @(negedge clk);
                    wr_next = 1'b0;
                    repeat (next_gap - 1) @(negedge clk);
                end
                if (parked) park_cnt++;
                else burst_cnt++;
            end
        end
    end

    initial begin : main_seq
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_disp_sel", 32'(disp_frame_sel), 32'(1));
        check("rst_wr_req", 32'(wr_req), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));

        // Seven words only: must not start a burst.
        enable = 1'b1;
        push(7);
        repeat (20) @(negedge clk);
        check("idle_no_reads", 32'(rd_total), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_disp_sel", 32'(disp_frame_sel), 32'(1));

        // First burst: words 0001..0008 to address 0.
        exp_addr_q.push_back(24'h000000);
        push(1);
        wait_bursts(1);
        check("reads_after_b1", 32'(rd_total), 32'(8));

        // Slow controller: late ack, spaced wr_next.
        ack_delay = 20;
        next_gap = 3;
        exp_addr_q.push_back(24'h000008);
        push(8);
        wait_bursts(2);
        check("reads_after_b2", 32'(rd_total), 32'(16));
        ack_delay = 2;
        next_gap = 1;

        // Finish frame 0 in buffer 0.
        exp_addr_q.push_back(24'h000010);
        exp_addr_q.push_back(24'h000018);
        push(16);
        wait_bursts(4);
        repeat (3) @(negedge clk);
        check("frame_cnt_1", 32'(frame_cnt), 32'(1));
        check("disp_sel_after_f0", 32'(disp_frame_sel), 32'(0));

        // Frame 1 in buffer 1, then wrap back to buffer 0.
        exp_addr_q.push_back(24'h080000);
        exp_addr_q.push_back(24'h080008);
        exp_addr_q.push_back(24'h080010);
        exp_addr_q.push_back(24'h080018);
        exp_addr_q.push_back(24'h000000);
        push(40);
        wait_bursts(8);
        repeat (3) @(negedge clk);
        check("frame_cnt_2", 32'(frame_cnt), 32'(2));
        check("disp_sel_after_f1", 32'(disp_frame_sel), 32'(1));
        wait_bursts(9);
        check("frame_cnt_still_2", 32'(frame_cnt), 32'(2));

        // Drop enable during FILL: burst still completes, then hold.
        exp_addr_q.push_back(24'h000008);
        push(8);
        t = 0;
        while (!cam_rd_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("fill_seen", 32'(cam_rd_en), 32'(1));
        enable = 1'b0;
        wait_bursts(10);
        push(8);
        repeat (30) @(negedge clk);
        check("disabled_reads", 32'(rd_total), 32'(80));
        check("disabled_busy", 32'(busy), 32'(0));
        exp_addr_q.push_back(24'h000010);
        enable = 1'b1;
        wait_bursts(11);
        check("reads_after_resume", 32'(rd_total), 32'(88));

        // Reset in the middle of STREAM after three words.
        exp_addr_q.push_back(24'h000018);
        stop_at = 3;
        push(8);
        t = 0;
        while (park_cnt == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("park_seen", 32'(park_cnt), 32'(1));
        check("words_left", 32'(exp_q.size()), 32'(5));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_wr_data", 32'(wr_data), 32'(0));
        check("midrst_wr_addr", 32'(wr_addr), 32'(0));
        check("midrst_wr_req", 32'(wr_req), 32'(0));
        check("midrst_rd_en", 32'(cam_rd_en), 32'(0));
        check("midrst_disp_sel", 32'(disp_frame_sel), 32'(1));
        // Words already pulled from the FIFO are lost.
        exp_q.delete();
        for (int i = fifo_rd; i < fifo_wr; i++) exp_q.push_back(16'(i + 1));
        stop_at = BURST_LEN;
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr_q.push_back(24'h000000);
        push(8);
        wait_bursts(12);
        check("reads_after_reset", 32'(rd_total), 32'(104));

        repeat (5) @(negedge clk);
        check("exp_data_drained", 32'(exp_q.size()), 32'(0));
        check("exp_addr_drained", 32'(exp_addr_q.size()), 32'(0));
        check("fifo_underflow", 32'(underflow), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
